// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, controller state encoding and
// the register-write payloads produced at trap time.
package cp0_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CODE_W    = 5;
    localparam int unsigned IRQ_W     = 6;

    localparam logic [XLEN-1:0] HANDLER_ADDR_DEF = 32'h0000_4180;

    localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RET     = 2'd3
    } cp0_state_e;

    // Cause register write bundle issued during the TRAP cycle
    typedef struct packed {
        logic              we;
        logic [CODE_W-1:0] code;
        logic              bd_set;
        logic              bd_clr;
    } cause_wr_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] value;
    } epc_wr_t;

    // A delay-slot instruction restarts at its branch, one word earlier
    function automatic logic [XLEN-1:0] epc_of(input logic [XLEN-1:0] pc,
                                               input logic            bd);
        return bd ? XLEN'(pc - XLEN'(4)) : pc;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for the device interrupt vector.
module irq_sync
    import cp0_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IRQ_W-1:0] d_i,
    output logic [IRQ_W-1:0] q_o
);

    logic [IRQ_W-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: arbitrates interrupts against M-stage
// exceptions, tracks EXL, and drives Cause/EPC write strobes and fetch redirect.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic [5:0]  im,
    input  logic        ie,
    input  logic        m_valid,
    input  logic        m_exc,
    input  logic [4:0]  m_exc_code,
    input  logic        m_bd,
    input  logic [31:0] m_pc,
    input  logic        m_eret,
    input  logic [31:0] epc,
    output logic        ECode_WE,
    output logic [4:0]  ExcCode,
    output logic        BDSet,
    output logic        BDClr,
    output logic        IP_WE,
    output logic [5:0]  IP,
    output logic        epc_we,
    output logic [31:0] epc_d,
    output logic        exl,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic [IRQ_W-1:0] ip_s;
    logic [IRQ_W-1:0] ip_q;
    logic             ip_we_q;

    cp0_state_e state_q, state_d;
    cause_wr_t  cause_q, cause_d;
    epc_wr_t    epc_wr_q, epc_wr_d;
    logic       exl_q, exl_d;

    logic irq_req;
    logic take_irq;
    logic take_exc;
    logic take_trap;
    logic take_eret;
    logic from_user;

    irq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (hw_int),
        .q_o   (ip_s)
    );

    // Interrupts are only accepted in RUN; the RET shadow keeps them out
    assign irq_req   = ie & ~exl_q & (|(ip_s & im)) & (state_q == ST_RUN);
    assign take_irq  = m_valid & irq_req;
    assign take_exc  = m_valid & m_exc & ~take_irq;
    assign take_trap = take_irq | take_exc;
    assign take_eret = m_valid & m_eret & ~m_exc & (state_q == ST_HANDLER);
    assign from_user = (state_q == ST_RUN) | (state_q == ST_RET);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        cause_d        = '{we: 1'b0, code: cause_q.code, bd_set: 1'b0, bd_clr: 1'b0};
        epc_wr_d       = '{we: 1'b0, value: epc_wr_q.value};

        if (take_trap) begin
            flush          = 1'b1;
            redirect       = 1'b1;
            redirect_pc    = HANDLER_ADDR;
            state_d        = ST_TRAP;
            cause_d.we     = 1'b1;
            cause_d.code   = take_irq ? EXC_INT : m_exc_code;
            cause_d.bd_set = m_bd;
            cause_d.bd_clr = ~m_bd;
            // A nested trap from the handler must not clobber the saved EPC
            if (from_user) begin
                epc_wr_d.we    = 1'b1;
                epc_wr_d.value = epc_of(m_pc, m_bd);
            end
        end else if (take_eret) begin
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = epc;
            state_d     = ST_RET;
        end else begin
            case (state_q)
                ST_TRAP: state_d = ST_HANDLER;
                ST_RET:  state_d = ST_RUN;
                default: state_d = state_q;
            endcase
        end

        exl_d = (state_d == ST_TRAP) | (state_d == ST_HANDLER);
    end

    // Trap-side register writes and EXL, issued one cycle after detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q  <= '0;
            epc_wr_q <= '0;
            exl_q    <= 1'b0;
        end else begin
            cause_q  <= cause_d;
            epc_wr_q <= epc_wr_d;
            exl_q    <= exl_d;
        end
    end

    // Pending-vector tracking for Cause.IP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ip_q    <= '0;
            ip_we_q <= 1'b0;
        end else begin
            ip_q    <= ip_s;
            ip_we_q <= (ip_s != ip_q);
        end
    end

    assign ECode_WE = cause_q.we;
    assign ExcCode  = cause_q.code;
    assign BDSet    = cause_q.bd_set;
    assign BDClr    = cause_q.bd_clr;
    assign IP_WE    = ip_we_q;
    assign IP       = ip_q;
    assign epc_we   = epc_wr_q.we;
    assign epc_d    = epc_wr_q.value;
    assign exl      = exl_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  hw_int;
    logic [5:0]  im;
    logic        ie;
    logic        m_valid;
    logic        m_exc;
    logic [4:0]  m_exc_code;
    logic        m_bd;
    logic [31:0] m_pc;
    logic        m_eret;
    logic [31:0] epc;
    logic        ECode_WE;
    logic [4:0]  ExcCode;
    logic        BDSet;
    logic        BDClr;
    logic        IP_WE;
    logic [5:0]  IP;
    logic        epc_we;
    logic [31:0] epc_d;
    logic        exl;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    cp0_exc_ctrl #(
        .HANDLER_ADDR (32'h0000_4180),
        .SYNC_STAGES  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hw_int      (hw_int),
        .im          (im),
        .ie          (ie),
        .m_valid     (m_valid),
        .m_exc       (m_exc),
        .m_exc_code  (m_exc_code),
        .m_bd        (m_bd),
        .m_pc        (m_pc),
        .m_eret      (m_eret),
        .epc         (epc),
        .ECode_WE    (ECode_WE),
        .ExcCode     (ExcCode),
        .BDSet       (BDSet),
        .BDClr       (BDClr),
        .IP_WE       (IP_WE),
        .IP          (IP),
        .epc_we      (epc_we),
        .epc_d       (epc_d),
        .exl         (exl),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; hw_int = '0; im = '0; ie = 1'b0;
        m_valid = 1'b0; m_exc = 1'b0; m_exc_code = '0; m_bd = 1'b0;
        m_pc = '0; m_eret = 1'b0; epc = '0;

        // Reset values
        #3;
        chk("rst_exl",   32'(exl), 32'd0);
        chk("rst_code",  32'(ExcCode), 32'd0);
        chk("rst_ip",    32'(IP), 32'd0);
        chk("rst_epcd",  epc_d, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_exl",   32'(exl), 32'd0);
            chk("idle_ecwe",  32'(ECode_WE), 32'd0);
            chk("idle_ipwe",  32'(IP_WE), 32'd0);
            chk("idle_epcwe", 32'(epc_we), 32'd0);
            chk("idle_flush", 32'(flush), 32'd0);
            chk("idle_redir", 32'(redirect), 32'd0);
            chk("idle_bd",    32'({BDSet, BDClr}), 32'd0);
        end

        // Interrupt from RUN
        ie = 1'b1; im = 6'h01; m_valid = 1'b1; m_pc = 32'h3008; m_bd = 1'b0; hw_int = 6'h01;
        tick();
        chk("irq_e1_flush", 32'(flush), 32'd0);
        chk("irq_e1_ipwe",  32'(IP_WE), 32'd0);
        tick();
        chk("irq_flush",    32'(flush), 32'd1);
        chk("irq_redir",    32'(redirect), 32'd1);
        chk("irq_rpc",      redirect_pc, 32'h4180);
        chk("irq_e2_ipwe",  32'(IP_WE), 32'd0);
        chk("irq_e2_exl",   32'(exl), 32'd0);
        tick();
        chk("irq_ipwe",   32'(IP_WE), 32'd1);
        chk("irq_ip",     32'(IP), 32'h01);
        chk("irq_ecwe",   32'(ECode_WE), 32'd1);
        chk("irq_code",   32'(ExcCode), 32'd0);
        chk("irq_bdclr",  32'(BDClr), 32'd1);
        chk("irq_bdset",  32'(BDSet), 32'd0);
        chk("irq_epcwe",  32'(epc_we), 32'd1);
        chk("irq_epcd",   epc_d, 32'h3008);
        chk("irq_exl",    32'(exl), 32'd1);
        chk("trap_flush", 32'(flush), 32'd0);
        m_valid = 1'b0;
        tick();
        chk("hdl_exl",   32'(exl), 32'd1);
        chk("hdl_ecwe",  32'(ECode_WE), 32'd0);
        chk("hdl_epcwe", 32'(epc_we), 32'd0);
        chk("hdl_ipwe",  32'(IP_WE), 32'd0);

        // Nested exception in HANDLER keeps EPC
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd4; m_pc = 32'h3020;
        #1;
        chk("nest_flush", 32'(flush), 32'd1);
        chk("nest_rpc",   redirect_pc, 32'h4180);
        tick();
        chk("nest_ecwe",  32'(ECode_WE), 32'd1);
        chk("nest_code",  32'(ExcCode), 32'd4);
        chk("nest_epcwe", 32'(epc_we), 32'd0);
        chk("nest_epcd",  epc_d, 32'h3008);
        chk("nest_exl",   32'(exl), 32'd1);
        m_valid = 1'b0; m_exc = 1'b0;
        tick();
        chk("nest_hdl_exl", 32'(exl), 32'd1);

        // ERET, then RET shadow blocks the still-pending interrupt
        epc = 32'h3008; m_valid = 1'b1; m_eret = 1'b1; m_pc = 32'h4200;
        #1;
        chk("eret_flush", 32'(flush), 32'd1);
        chk("eret_redir", 32'(redirect), 32'd1);
        chk("eret_rpc",   redirect_pc, 32'h3008);
        tick();
        chk("ret_exl", 32'(exl), 32'd0);
        m_eret = 1'b0; m_pc = 32'h3008;
        #1;
        chk("ret_noirq", 32'(flush), 32'd0);
        tick();
        chk("run_irq_flush", 32'(flush), 32'd1);
        chk("run_irq_rpc",   redirect_pc, 32'h4180);
        tick();
        chk("irq2_code",  32'(ExcCode), 32'd0);
        chk("irq2_epcwe", 32'(epc_we), 32'd1);
        chk("irq2_epcd",  epc_d, 32'h3008);
        chk("irq2_exl",   32'(exl), 32'd1);
        m_valid = 1'b0;
        tick();

        // Drop the interrupt line while returning
        hw_int = 6'h00; epc = 32'h3008; m_valid = 1'b1; m_eret = 1'b1;
        tick();
        chk("ret2_exl", 32'(exl), 32'd0);
        m_valid = 1'b0; m_eret = 1'b0;
        tick();
        chk("fall_ipwe0", 32'(IP_WE), 32'd0);
        tick();
        chk("fall_ipwe", 32'(IP_WE), 32'd1);
        chk("fall_ip",   32'(IP), 32'd0);

        // ERET outside HANDLER does nothing
        m_valid = 1'b1; m_eret = 1'b1;
        #1;
        chk("nop_eret_flush", 32'(flush), 32'd0);
        chk("nop_eret_redir", 32'(redirect), 32'd0);
        tick();
        chk("nop_eret_exl", 32'(exl), 32'd0);
        m_valid = 1'b0; m_eret = 1'b0;

        // Exception in a delay slot
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd12; m_bd = 1'b1; m_pc = 32'h3010;
        #1;
        chk("bd_flush", 32'(flush), 32'd1);
        tick();
        chk("bd_code",  32'(ExcCode), 32'd12);
        chk("bd_set",   32'(BDSet), 32'd1);
        chk("bd_clr",   32'(BDClr), 32'd0);
        chk("bd_epcwe", 32'(epc_we), 32'd1);
        chk("bd_epcd",  epc_d, 32'h300C);
        m_valid = 1'b0; m_exc = 1'b0; m_bd = 1'b0;
        tick();
        epc = 32'h300C; m_valid = 1'b1; m_eret = 1'b1;
        tick();
        m_valid = 1'b0; m_eret = 1'b0;
        tick();

        // Interrupt deferred by bubbles, then beats a simultaneous exception
        hw_int = 6'h01;
        tick(); tick();
        chk("defer_flush0", 32'(flush), 32'd0);
        tick();
        chk("defer_flush1", 32'(flush), 32'd0);
        chk("defer_exl",    32'(exl), 32'd0);
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd10; m_pc = 32'h3040;
        #1;
        chk("prio_flush", 32'(flush), 32'd1);
        tick();
        chk("prio_code",  32'(ExcCode), 32'd0);
        chk("prio_epcd",  epc_d, 32'h3040);
        chk("prio_bdclr", 32'(BDClr), 32'd1);
        m_valid = 1'b0; m_exc = 1'b0;
        tick();
        epc = 32'h3040; m_valid = 1'b1; m_eret = 1'b1;
        tick();
        m_valid = 1'b0; m_eret = 1'b0; im = 6'h00;
        tick();

        // EPC wrap at zero, then reset in the middle of TRAP
        m_valid = 1'b1; m_exc = 1'b1; m_exc_code = 5'd5; m_bd = 1'b1; m_pc = 32'h0;
        #1;
        chk("wrap_flush", 32'(flush), 32'd1);
        tick();
        chk("wrap_epcd", epc_d, 32'hFFFF_FFFC);
        chk("wrap_code", 32'(ExcCode), 32'd5);
        chk("wrap_bdset", 32'(BDSet), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_ecwe",  32'(ECode_WE), 32'd0);
        chk("mid_rst_epcwe", 32'(epc_we), 32'd0);
        chk("mid_rst_bd",    32'({BDSet, BDClr}), 32'd0);
        chk("mid_rst_exl",   32'(exl), 32'd0);
        chk("mid_rst_code",  32'(ExcCode), 32'd0);
        chk("mid_rst_epcd",  epc_d, 32'd0);
        m_valid = 1'b0; m_exc = 1'b0; m_bd = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_exl",  32'(exl), 32'd0);
        chk("post_rst_ecwe", 32'(ECode_WE), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
